// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared types and widths for the NoC injection interface
// Purpose: flit type encoding, flit struct, field widths and FSM state type.
package noc_pkg;

  localparam int FLIT_W    = 16;
  localparam int PAYLOAD_W = 14;
  localparam int DEST_W    = 4;
  localparam int LEN_W     = 4;
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_TAIL     = 2'b01,
    FLIT_HEAD     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e           ftype;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_e;

  // Head payload: zero padding above {dest, len}.
  function automatic logic [PAYLOAD_W-1:0] head_payload(input logic [DEST_W-1:0] dest,
                                                        input logic [LEN_W-1:0]  len);
    return {{(PAYLOAD_W-DEST_W-LEN_W){1'b0}}, dest, len};
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// rtl/noc_credit_counter.sv - credit counter with sticky overflow flag
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   inc             credit returned by the router this cycle
//   dec             flit issued this cycle (only asserted while can_send)
//   count           current credit count
//   can_send        count is non-zero
//   overflow        sticky: a credit arrived while already full with no issue
module noc_credit_counter
  import noc_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             can_send,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] INIT = CNT_W'(CREDITS);

  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (inc && !dec) begin
      // A credit beyond the buffer depth is a protocol error; the count saturates.
      if (count_q == INIT) overflow_d = 1'b1;
      else                 count_d    = count_q + 1'b1;
    end else if (dec && !inc) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= INIT;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign can_send = (count_q != '0);
  assign overflow = overflow_q;

endmodule

// File: rtl/noc_inject_ni.sv
// rtl/noc_inject_ni.sv - credit-based packet-to-flit injection network interface
// Ports:
//   clk, rst                                clock, asynchronous active-low reset
//   msg_valid_i/msg_ready_o/dest/len        packet header handshake from core
//   word_valid_i/word_ready_o/word_data_i   payload word handshake from core
//   valid_o, data_o                         registered flit towards router
//   credit_i                                credit return pulse from router
//   credits_o, err_o                        credit count, sticky overflow error
module noc_inject_ni
  import noc_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 msg_valid_i,
  output logic                 msg_ready_o,
  input  logic [DEST_W-1:0]    msg_dest_i,
  input  logic [LEN_W-1:0]     msg_len_i,
  input  logic                 word_valid_i,
  output logic                 word_ready_o,
  input  logic [PAYLOAD_W-1:0] word_data_i,
  output logic                 valid_o,
  output logic [FLIT_W-1:0]    data_o,
  input  logic                 credit_i,
  output logic [CNT_W-1:0]     credits_o,
  output logic                 err_o
);

  state_e             state_q, state_d;
  logic [DEST_W-1:0]  dest_q, dest_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               valid_q, valid_d;
  flit_t              data_q, data_d;

  logic               issue;
  logic               can_send;
  flit_t              flit;

  noc_credit_counter #(.CREDITS(CREDITS)) u_credit (
    .clk      (clk),
    .rst      (rst),
    .inc      (credit_i),
    .dec      (issue),
    .count    (credits_o),
    .can_send (can_send),
    .overflow (err_o)
  );

  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    len_d        = len_q;
    remaining_d  = remaining_q;
    issue        = 1'b0;
    flit         = '0;
    msg_ready_o  = 1'b0;
    word_ready_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        msg_ready_o = 1'b1;
        if (msg_valid_i) begin
          dest_d  = msg_dest_i;
          len_d   = msg_len_i;
          state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (can_send) begin
          issue        = 1'b1;
          flit.payload = head_payload(dest_q, len_q);
          if (len_q == '0) begin
            flit.ftype = FLIT_HEADTAIL;
            state_d    = ST_IDLE;
          end else begin
            flit.ftype  = FLIT_HEAD;
            remaining_d = len_q;
            state_d     = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        word_ready_o = can_send;
        if (word_valid_i && can_send) begin
          issue        = 1'b1;
          flit.payload = word_data_i;
          remaining_d  = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            flit.ftype = FLIT_TAIL;
            state_d    = ST_IDLE;
          end else begin
            flit.ftype = FLIT_BODY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output register: pulse valid for one cycle, data holds the last flit.
    valid_d = issue;
    data_d  = issue ? flit : data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      dest_q      <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_noc_inject_ni.sv
// tb/tb_noc_inject_ni.sv - scoreboard testbench for noc_inject_ni
module tb_noc_inject_ni;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT with default depth 4
  logic        msg_valid_i = 0, msg_ready_o, word_valid_i = 0, word_ready_o;
  logic [3:0]  msg_dest_i = 0, msg_len_i = 0;
  logic [13:0] word_data_i = 0;
  logic        valid_o, credit_i = 0, err_o;
  logic [15:0] data_o;
  logic [2:0]  credits_o;

  // DUT with depth 2
  logic        msg_valid2 = 0, msg_ready2, word_valid2 = 0, word_ready2;
  logic [3:0]  msg_dest2 = 0, msg_len2 = 0;
  logic [13:0] word_data2 = 0;
  logic        valid2, credit2 = 0, err2;
  logic [15:0] data2;
  logic [2:0]  credits2;

  noc_inject_ni dut (
    .clk(clk), .rst(rst),
    .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
    .msg_dest_i(msg_dest_i), .msg_len_i(msg_len_i),
    .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .word_data_i(word_data_i),
    .valid_o(valid_o), .data_o(data_o), .credit_i(credit_i),
    .credits_o(credits_o), .err_o(err_o)
  );

  noc_inject_ni #(.CREDITS(2)) dut2 (
    .clk(clk), .rst(rst),
    .msg_valid_i(msg_valid2), .msg_ready_o(msg_ready2),
    .msg_dest_i(msg_dest2), .msg_len_i(msg_len2),
    .word_valid_i(word_valid2), .word_ready_o(word_ready2), .word_data_i(word_data2),
    .valid_o(valid2), .data_o(data2), .credit_i(credit2),
    .credits_o(credits2), .err_o(err2)
  );

  logic [15:0] exp_q[$];
  logic [15:0] exp2_q[$];
  logic [15:0] mon_e, mon_e2;
  int vectors = 0;
  int errs = 0;

  function automatic logic [15:0] head_flit(input logic [3:0] d, input logic [3:0] l);
    return {(l == 4'd0) ? 2'b11 : 2'b10, 6'b000000, d, l};
  endfunction

  function automatic logic [15:0] word_flit(input logic [13:0] w, input bit last);
    return {last ? 2'b01 : 2'b00, w};
  endfunction

  // Scoreboards: every observed flit must match the oldest expected one.
  always @(negedge clk) begin
    if (rst && valid_o) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errs++; $display("FAIL flit_unexpected: got %h, required no flit", data_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (data_o !== mon_e) begin
          errs++; $display("FAIL flit_data: got %h, required %h", data_o, mon_e);
        end
      end
    end
    if (rst && valid2) begin
      vectors++;
      if (exp2_q.size() == 0) begin
        errs++; $display("FAIL flit2_unexpected: got %h, required no flit", data2);
      end else begin
        mon_e2 = exp2_q.pop_front();
        if (data2 !== mon_e2) begin
          errs++; $display("FAIL flit2_data: got %h, required %h", data2, mon_e2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_credit(input int n);
    for (int i = 0; i < n; i++) begin
      credit_i = 1'b1; tick(); credit_i = 1'b0;
    end
  endtask

  task automatic send_msg(input logic [3:0] d, input logic [3:0] l);
    bit ok = 0;
    msg_valid_i = 1'b1; msg_dest_i = d; msg_len_i = l;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (msg_ready_o) begin ok = 1; exp_q.push_back(head_flit(d, l)); end
      tick();
    end
    msg_valid_i = 1'b0;
    vectors++;
    if (!ok) begin errs++; $display("FAIL msg_handshake: got timeout, required accept"); end
  endtask

  task automatic send_word(input logic [13:0] w, input bit last);
    bit ok = 0;
    word_valid_i = 1'b1; word_data_i = w;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (word_ready_o) begin ok = 1; exp_q.push_back(word_flit(w, last)); end
      tick();
    end
    word_valid_i = 1'b0;
    vectors++;
    if (!ok) begin errs++; $display("FAIL word_handshake: got timeout, required accept"); end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp2_q.size() != 0); i++) tick();
    tick(); tick();
    vectors++;
    if (exp_q.size() + exp2_q.size() != 0) begin
      errs++; $display("FAIL drain: got %0d outstanding, required 0", exp_q.size() + exp2_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; tick(); tick();
    vectors += 7;
    if (msg_ready_o !== 1'b1)  begin errs++; $display("FAIL rst_msg_ready: got %b, required 1", msg_ready_o); end
    if (word_ready_o !== 1'b0) begin errs++; $display("FAIL rst_word_ready: got %b, required 0", word_ready_o); end
    if (valid_o !== 1'b0)      begin errs++; $display("FAIL rst_valid: got %b, required 0", valid_o); end
    if (data_o !== 16'h0000)   begin errs++; $display("FAIL rst_data: got %h, required 0000", data_o); end
    if (credits_o !== 3'd4)    begin errs++; $display("FAIL rst_credits: got %0d, required 4", credits_o); end
    if (err_o !== 1'b0)        begin errs++; $display("FAIL rst_err: got %b, required 0", err_o); end
    if (credits2 !== 3'd2)     begin errs++; $display("FAIL rst_credits2: got %0d, required 2", credits2); end
    rst = 1'b1; tick();
  endtask

  task automatic test_headtail();
    send_msg(4'h5, 4'h0);
    vectors += 5;
    if (valid_o !== 1'b0)     begin errs++; $display("FAIL ht_early: got valid %b, required 0", valid_o); end
    if (msg_ready_o !== 1'b0) begin errs++; $display("FAIL ht_head_ready: got %b, required 0", msg_ready_o); end
    tick();
    if (valid_o !== 1'b1)     begin errs++; $display("FAIL ht_valid: got %b, required 1", valid_o); end
    if (credits_o !== 3'd3)   begin errs++; $display("FAIL ht_credits: got %0d, required 3", credits_o); end
    tick();
    if (valid_o !== 1'b0 || data_o !== 16'hC050) begin
      errs++; $display("FAIL ht_hold: got valid %b data %h, required 0 C050", valid_o, data_o);
    end
    pulse_credit(1);
    vectors++;
    if (credits_o !== 3'd4 || err_o !== 1'b0) begin
      errs++; $display("FAIL ht_return: got %0d err %b, required 4 0", credits_o, err_o);
    end
    drain();
  endtask

  task automatic test_packet();
    send_msg(4'h2, 4'h3);
    send_word(14'h0001, 0);
    send_word(14'h0002, 0);
    send_word(14'h0003, 1);
    drain();
    vectors += 3;
    if (credits_o !== 3'd0) begin errs++; $display("FAIL pkt_credits: got %0d, required 0", credits_o); end
    if (data_o !== 16'h4003) begin errs++; $display("FAIL pkt_last: got %h, required 4003", data_o); end
    if (msg_ready_o !== 1'b1 || word_ready_o !== 1'b0) begin
      errs++; $display("FAIL pkt_idle: got %b %b, required 1 0", msg_ready_o, word_ready_o);
    end
  endtask

  task automatic test_zero_credit_stall();
    send_msg(4'h3, 4'h0);
    tick(); tick(); tick();
    vectors += 3;
    if (valid_o !== 1'b0 || msg_ready_o !== 1'b0) begin
      errs++; $display("FAIL stall_hold: got valid %b ready %b, required 0 0", valid_o, msg_ready_o);
    end
    credit_i = 1'b1; tick(); credit_i = 1'b0;
    if (valid_o !== 1'b0 || credits_o !== 3'd1) begin
      errs++; $display("FAIL stall_same_cycle: got valid %b credits %0d, required 0 1", valid_o, credits_o);
    end
    tick();
    if (valid_o !== 1'b1 || credits_o !== 3'd0) begin
      errs++; $display("FAIL stall_release: got valid %b credits %0d, required 1 0", valid_o, credits_o);
    end
    drain();
  endtask

  task automatic test_credit_and_issue_same_cycle();
    pulse_credit(1);
    send_msg(4'h1, 4'h1);
    credit_i = 1'b1; tick(); credit_i = 1'b0;
    vectors++;
    if (credits_o !== 3'd1 || valid_o !== 1'b1) begin
      errs++; $display("FAIL same_cycle: got credits %0d valid %b, required 1 1", credits_o, valid_o);
    end
    send_word(14'h3ABC, 1);
    drain();
    pulse_credit(4);
    vectors++;
    if (credits_o !== 3'd4 || err_o !== 1'b0) begin
      errs++; $display("FAIL refill: got %0d err %b, required 4 0", credits_o, err_o);
    end
  endtask

  task automatic test_overflow();
    pulse_credit(1);
    vectors += 3;
    if (credits_o !== 3'd4 || err_o !== 1'b1) begin
      errs++; $display("FAIL ovf: got %0d err %b, required 4 1", credits_o, err_o);
    end
    send_msg(4'h6, 4'h0);
    drain();
    if (err_o !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b, required 1", err_o); end
    pulse_credit(1);
    if (credits_o !== 3'd4 || err_o !== 1'b1) begin
      errs++; $display("FAIL ovf_sticky2: got %0d err %b, required 4 1", credits_o, err_o);
    end
  endtask

  task automatic test_back_to_back();
    send_msg(4'hA, 4'h0);
    tick();
    vectors++;
    if (valid_o !== 1'b1 || msg_ready_o !== 1'b1) begin
      errs++; $display("FAIL b2b_ready: got valid %b ready %b, required 1 1", valid_o, msg_ready_o);
    end
    send_msg(4'hB, 4'h1);
    send_word(14'h0155, 1);
    drain();
    pulse_credit(3);
    vectors++;
    if (credits_o !== 3'd4) begin errs++; $display("FAIL b2b_credits: got %0d, required 4", credits_o); end
  endtask

  task automatic test_reset_mid();
    send_msg(4'h7, 4'h3);
    send_word(14'h0001, 0);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    vectors += 6;
    if (valid_o !== 1'b0)      begin errs++; $display("FAIL mid_valid: got %b, required 0", valid_o); end
    if (credits_o !== 3'd4)    begin errs++; $display("FAIL mid_credits: got %0d, required 4", credits_o); end
    if (msg_ready_o !== 1'b1)  begin errs++; $display("FAIL mid_msg_ready: got %b, required 1", msg_ready_o); end
    if (word_ready_o !== 1'b0) begin errs++; $display("FAIL mid_word_ready: got %b, required 0", word_ready_o); end
    if (err_o !== 1'b0)        begin errs++; $display("FAIL mid_err: got %b, required 0", err_o); end
    if (data_o !== 16'h0000)   begin errs++; $display("FAIL mid_data: got %h, required 0000", data_o); end
    tick(); tick();
    rst = 1'b1;
    send_msg(4'h8, 4'h0);
    vectors++;
    if (msg_ready_o !== 1'b0) begin errs++; $display("FAIL first_edge: got ready %b, required 0", msg_ready_o); end
    drain();
    tick(); tick(); tick();
    pulse_credit(1);
  endtask

  task automatic test_credit_exhaust();
    bit ok = 0;
    msg_valid2 = 1'b1; msg_dest2 = 4'h9; msg_len2 = 4'h3;
    exp2_q.push_back(head_flit(4'h9, 4'h3));
    tick(); msg_valid2 = 1'b0;
    word_valid2 = 1'b1; word_data2 = 14'h0011;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (word_ready2) begin ok = 1; exp2_q.push_back(word_flit(14'h0011, 0)); end
      tick();
    end
    word_data2 = 14'h0012;
    tick(); tick();
    vectors += 5;
    if (!ok) begin errs++; $display("FAIL ex_first_word: got timeout, required accept"); end
    if (credits2 !== 3'd0 || word_ready2 !== 1'b0 || valid2 !== 1'b0) begin
      errs++; $display("FAIL ex_stalled: got credits %0d ready %b valid %b, required 0 0 0", credits2, word_ready2, valid2);
    end
    credit2 = 1'b1; tick(); credit2 = 1'b0;
    if (credits2 !== 3'd1 || word_ready2 !== 1'b1 || valid2 !== 1'b0) begin
      errs++; $display("FAIL ex_credit: got credits %0d ready %b valid %b, required 1 1 0", credits2, word_ready2, valid2);
    end
    exp2_q.push_back(word_flit(14'h0012, 0));
    tick();
    word_data2 = 14'h0013;
    if (valid2 !== 1'b1 || word_ready2 !== 1'b0 || credits2 !== 3'd0) begin
      errs++; $display("FAIL ex_one_flit: got valid %b ready %b credits %0d, required 1 0 0", valid2, word_ready2, credits2);
    end
    tick();
    if (valid2 !== 1'b0) begin errs++; $display("FAIL ex_only_one: got valid %b, required 0", valid2); end
    credit2 = 1'b1; tick(); credit2 = 1'b0;
    exp2_q.push_back(word_flit(14'h0013, 1));
    tick();
    word_valid2 = 1'b0;
    drain();
    vectors++;
    if (msg_ready2 !== 1'b1) begin errs++; $display("FAIL ex_idle: got %b, required 1", msg_ready2); end
  endtask

  initial begin
    test_reset();
    test_headtail();
    test_packet();
    test_zero_credit_stall();
    test_credit_and_issue_same_cycle();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_credit_exhaust();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/noc_inject_ni.md
NOC_INJECT_NI -- requirements
Module: noc_inject_ni

Interface
REQ-001 SHALL have parameter CREDITS, default 4, meaning initial credit count equal to downstream router input buffer depth (legal 1..7).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port msg_valid_i  input  1  core offers a packet header.
REQ-005 SHALL have port msg_ready_o  output  1  header accepted when msg_valid_i && msg_ready_o.
REQ-006 SHALL have port msg_dest_i  input  4  destination node id.
REQ-007 SHALL have port msg_len_i  input  4  number of payload words, 0..15.
REQ-008 SHALL have port word_valid_i  input  1  core offers a payload word.
REQ-009 SHALL have port word_ready_o  output  1  word accepted when word_valid_i && word_ready_o.
REQ-010 SHALL have port word_data_i  input  14  payload word.
REQ-011 SHALL have port valid_o  output  1  flit valid, drives router valid_i.
REQ-012 SHALL have port data_o  output  16  flit, drives router data_i.
REQ-013 SHALL have port credit_i  input  1  one-cycle credit return pulse from router credit_o.
REQ-014 SHALL have port credits_o  output  3  current credit count.
REQ-015 SHALL have port err_o  output  1  sticky credit-overflow error.

Function
REQ-016 Flit format SHALL be data[15:14]=type (HEAD 2'b10, BODY 2'b00, TAIL 2'b01, HEADTAIL 2'b11), data[13:0]=payload.
REQ-017 Head payload SHALL be {6'b0, dest[3:0], len[3:0]}; body/tail payload SHALL be word_data_i.
REQ-018 FSM SHALL have states IDLE, HEAD, BODY.
REQ-019 IDLE: msg_ready_o=1; on handshake latch dest/len, go HEAD; else stay.
REQ-020 HEAD: when credits>0 issue head flit (HEADTAIL if len==0); len==0 -> IDLE, else load remaining=len -> BODY; credits==0 -> stall in HEAD.
REQ-021 BODY: word_ready_o = (credits>0); on word handshake issue BODY, or TAIL when remaining==1 then -> IDLE; remaining decrements per word.
REQ-022 msg_ready_o SHALL be 0 outside IDLE; word_ready_o SHALL be 0 outside BODY.
REQ-023 valid_o/data_o SHALL be registered: a flit issued in cycle N appears with valid_o=1 in cycle N+1 for exactly one cycle; valid_o=0 otherwise and data_o holds last value.
REQ-024 Credit count SHALL decrement by 1 per issued flit, increment by 1 per credit_i pulse; both in same cycle -> unchanged.
REQ-025 A flit SHALL never issue when credits==0, including a credit_i arriving that same cycle (usable next cycle).
REQ-026 credit_i when credits==CREDITS and no issue SHALL leave count at CREDITS and set err_o=1 until reset.
REQ-027 Back-to-back packets SHALL be allowed: IDLE accepts new header the cycle after TAIL/HEADTAIL issue.

Reset
REQ-028 Asserting rst (low) SHALL immediately force: state IDLE, credits=CREDITS, valid_o=0, data_o=16'h0000, err_o=0, remaining=0, msg_ready_o=1, word_ready_o=0.
REQ-029 Reset mid-packet SHALL abandon the packet; no tail is emitted after release.
REQ-030 After release, first header handshake SHALL be possible in the first clock edge.

Structure
REQ-031 noc_pkg SHALL hold flit type enum, FLIT_W=16, PAYLOAD_W=14, DEST_W=4, LEN_W=4 and flit struct.
REQ-032 Credit logic SHALL be a sub-module noc_credit_counter (params CREDITS; ports inc, dec, count, can_send, overflow).

Verification
REQ-033 dest=4'h5, len=0, credits=4 -> one flit 16'hC050 one cycle after HEAD; credits_o=3.
REQ-034 dest=4'h2, len=3, words 14'h0001/0002/0003, credit_i never -> flits 16'h8023, 16'h0001, 16'h0002, 16'h4003; credits_o=0.
REQ-035 credits exhausted mid-packet (CREDITS=2, len=3) -> word_ready_o=0 after 2 flits; one credit_i pulse -> exactly one more flit next cycle.
REQ-036 credit_i and flit issue same cycle at credits=1 -> credits_o stays 1.
REQ-037 credit_i at credits=4, idle -> credits_o=4, err_o=1 sticky until rst.
REQ-038 rst low during BODY after 1 of 3 words -> valid_o=0, credits_o=4, msg_ready_o=1 immediately; no TAIL seen.
